// File: rtl/bin_to_bcd_serial.sv
// rtl/bin_to_bcd_serial.sv - 8-bit binary to 3-digit packed BCD, one shift-add-3 step per clock
module bin_to_bcd_serial (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic [11:0] bcd,
  output logic        done,
  output logic        busy,
  output logic        over99
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state, state_nxt;
  logic [7:0]  sr;
  logic [11:0] acc;
  logic [2:0]  cnt;
  logic [11:0] acc_shift;
  logic        last;

  function automatic logic [3:0] fix(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Hundreds never exceeds 2, so the bit shifted out of the accumulator is always 0.
  assign acc_shift = 12'({fix(acc[11:8]), fix(acc[7:4]), fix(acc[3:0]), sr[7]});
  assign last      = (cnt == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr     <= '0;
      acc    <= '0;
      cnt    <= '0;
      bcd    <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      over99 <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr   <= bin;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b1;
          end
        end
        SHIFT: begin
          sr  <= {sr[6:0], 1'b0};
          acc <= acc_shift;
          cnt <= cnt + 3'd1;
          // Result is published only here so the display never shows partial values.
          if (last) begin
            bcd    <= acc_shift;
            over99 <= |acc_shift[11:8];
            done   <= 1'b1;
            busy   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
